// File: rtl/ysyx_mdu_pkg.sv
// ysyx_mdu shared types: funct3 op encodings, FSM states and op
// classification helpers used by the multiply/divide unit.
package ysyx_mdu_pkg;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } mdu_state_e;

   function automatic logic op_is_div(input mdu_op_e op);
      return op[2];
   endfunction

   function automatic logic op_is_rem(input mdu_op_e op);
      return (op == MDU_REM) || (op == MDU_REMU);
   endfunction

   function automatic logic op1_signed(input mdu_op_e op);
      return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
             (op == MDU_DIV) || (op == MDU_REM);
   endfunction

   function automatic logic op2_signed(input mdu_op_e op);
      return (op == MDU_MUL) || (op == MDU_MULH) ||
             (op == MDU_DIV) || (op == MDU_REM);
   endfunction

endpackage

// File: rtl/ysyx_mdu_div_step.sv
// One combinational restoring-divide step.
// Ports: i_rem partial remainder, i_bit next dividend bit, i_dvs divisor,
//        o_rem next partial remainder, o_q resulting quotient bit.
module ysyx_mdu_div_step #(
   parameter int BIT_W = 32
) (
   input  logic [BIT_W-1:0] i_rem,
   input  logic             i_bit,
   input  logic [BIT_W-1:0] i_dvs,
   output logic [BIT_W-1:0] o_rem,
   output logic             o_q
);

   logic [BIT_W:0] w_trial;
   logic [BIT_W:0] w_diff;

   assign w_trial = {i_rem, i_bit};
   assign w_diff  = w_trial - {1'b0, i_dvs};
   // i_rem < i_dvs keeps the trial below 2*divisor, so the top bit of the
   // difference is a clean borrow flag
   assign o_q     = ~w_diff[BIT_W];
   assign o_rem   = o_q ? w_diff[BIT_W-1:0] : w_trial[BIT_W-1:0];

endmodule

// File: rtl/ysyx_mdu.sv
// Iterative RV M-extension multiply/divide unit, STEP result bits per cycle.
// Ports: clk, rst (sync, active-low); prev_valid/ready_o accept handshake
//        with op, op1, op2, rd; valid_o/next_ready result handshake with
//        result_o, rd_o; flush kills any in-flight or unconsumed op.
module ysyx_mdu
   import ysyx_mdu_pkg::*;
#(
   parameter int BIT_W = 32,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             prev_valid,
   output logic             ready_o,
   input  logic [2:0]       op,
   input  logic [BIT_W-1:0] op1,
   input  logic [BIT_W-1:0] op2,
   input  logic [4:0]       rd,
   input  logic             flush,
   output logic             valid_o,
   input  logic             next_ready,
   output logic [BIT_W-1:0] result_o,
   output logic [4:0]       rd_o
);

   localparam int N  = BIT_W / STEP;
   localparam int CW = $clog2(N + 1);
   localparam int W2 = 2 * BIT_W;
   localparam logic [BIT_W-1:0] MIN_INT = {1'b1, {(BIT_W-1){1'b0}}};

   mdu_state_e       r_state;
   logic [CW-1:0]    r_cnt;
   mdu_op_e          r_op;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [W2-1:0]    r_acc;
   logic [W2-1:0]    r_mc;
   logic [BIT_W-1:0] r_mpl;
   logic [BIT_W-1:0] r_rem;
   logic [BIT_W-1:0] r_quo;
   logic [BIT_W-1:0] r_dvs;
   logic [BIT_W-1:0] r_res;
   logic [4:0]       r_rd;

   // accept-time decode
   mdu_op_e          w_op;
   logic             w_s1;
   logic             w_s2;
   logic [BIT_W-1:0] w_mag1;
   logic [BIT_W-1:0] w_mag2;
   logic             w_div0;
   logic             w_ovf;
   logic             w_fast;
   logic [BIT_W-1:0] w_fast_res;

   assign w_op   = mdu_op_e'(op);
   assign w_s1   = op1_signed(w_op) & op1[BIT_W-1];
   assign w_s2   = op2_signed(w_op) & op2[BIT_W-1];
   assign w_mag1 = w_s1 ? -op1 : op1;
   assign w_mag2 = w_s2 ? -op2 : op2;
   assign w_div0 = (op2 == '0);
   assign w_ovf  = ((w_op == MDU_DIV) || (w_op == MDU_REM)) &&
                   (op1 == MIN_INT) && (op2 == '1);
   assign w_fast = op_is_div(w_op) && (w_div0 || w_ovf);

   always_comb begin
      w_fast_res = '1;
      if (w_div0)
         w_fast_res = op_is_rem(w_op) ? op1 : '1;
      else
         w_fast_res = op_is_rem(w_op) ? '0 : MIN_INT;
   end

   // multiply: add multiplicand shifted by each bit of the STEP-bit slice
   logic [W2-1:0] w_part;
   logic [W2-1:0] w_acc_nx;
   logic [W2-1:0] w_prod;

   always_comb begin
      w_part = '0;
      for (int j = 0; j < STEP; j++)
         if (r_mpl[j])
            w_part = w_part + (r_mc << j);
   end

   assign w_acc_nx = r_acc + w_part;
   assign w_prod   = r_neg_q ? -w_acc_nx : w_acc_nx;

   // divide: STEP restoring steps chained, dividend bits consumed MSB first
   logic [BIT_W-1:0] w_rem [STEP+1];
   logic [STEP-1:0]  w_qb;
   logic [BIT_W-1:0] w_quo_nx;
   logic [BIT_W-1:0] w_q_fin;
   logic [BIT_W-1:0] w_r_fin;

   assign w_rem[0] = r_rem;

   for (genvar k = 0; k < STEP; k++) begin : g_div
      ysyx_mdu_div_step #(.BIT_W(BIT_W)) u_step (
         .i_rem (w_rem[k]),
         .i_bit (r_quo[BIT_W-1-k]),
         .i_dvs (r_dvs),
         .o_rem (w_rem[k+1]),
         .o_q   (w_qb[STEP-1-k])
      );
   end

   assign w_quo_nx = (r_quo << STEP) | BIT_W'(w_qb);
   assign w_q_fin  = r_neg_q ? -w_quo_nx : w_quo_nx;
   assign w_r_fin  = r_neg_r ? -w_rem[STEP] : w_rem[STEP];

   logic [BIT_W-1:0] w_fin;

   always_comb begin
      w_fin = '0;
      unique case (r_op)
         MDU_MUL:    w_fin = w_prod[BIT_W-1:0];
         MDU_MULH,
         MDU_MULHSU,
         MDU_MULHU:  w_fin = w_prod[W2-1:BIT_W];
         MDU_DIV,
         MDU_DIVU:   w_fin = w_q_fin;
         MDU_REM,
         MDU_REMU:   w_fin = w_r_fin;
         default:    w_fin = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_res   <= '0;
         r_rd    <= '0;
      end else if (flush) begin
         r_state <= S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (prev_valid) begin
                  r_op    <= w_op;
                  r_rd    <= rd;
                  r_cnt   <= '0;
                  r_neg_q <= w_s1 ^ w_s2;
                  r_neg_r <= w_s1;
                  r_acc   <= '0;
                  r_mc    <= W2'(w_mag2);
                  r_mpl   <= w_mag1;
                  r_rem   <= '0;
                  r_quo   <= w_mag1;
                  r_dvs   <= w_mag2;
                  if (w_fast) begin
                     r_res   <= w_fast_res;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               r_acc <= w_acc_nx;
               r_mc  <= r_mc << STEP;
               r_mpl <= r_mpl >> STEP;
               r_rem <= w_rem[STEP];
               r_quo <= w_quo_nx;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(N - 1)) begin
                  r_res   <= w_fin;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (next_ready)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ready_o  = (r_state == S_IDLE) && rst;
   assign valid_o  = (r_state == S_DONE) && rst;
   assign result_o = r_res;
   assign rd_o     = r_rd;

endmodule

// File: tb/tb_ysyx_mdu.sv
// Self-checking bench for ysyx_mdu: three instances (STEP 1, 2, 4) share
// stimulus and are compared every cycle against a behavioural model.
module tb_ysyx_mdu;

   localparam logic [31:0] MIN = 32'h8000_0000;

   logic        clk = 0;
   logic        rst = 0;
   logic        prev_valid = 0;
   logic [2:0]  op = 0;
   logic [31:0] op1 = 0;
   logic [31:0] op2 = 0;
   logic [4:0]  rd = 0;
   logic        flush = 0;
   logic        next_ready = 1;

   logic        rdy [3];
   logic        vld [3];
   logic [31:0] res [3];
   logic [4:0]  rdo [3];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      ysyx_mdu #(.BIT_W(32), .STEP(1 << g)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .prev_valid (prev_valid),
         .ready_o    (rdy[g]),
         .op         (op),
         .op1        (op1),
         .op2        (op2),
         .rd         (rd),
         .flush      (flush),
         .valid_o    (vld[g]),
         .next_ready (next_ready),
         .result_o   (res[g]),
         .rd_o       (rdo[g])
      );
   end

   task automatic chk(input string nm, input int k,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc %0d got %h want %h",
                  nm, k, cyc, act, exp);
      end
   endtask

   // reference arithmetic straight from the M-extension definitions
   function automatic logic [31:0] ref_op(input logic [2:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb;
      logic [63:0] ua, ub, p;
      logic signed [31:0] q;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      p = '0;
      case (o)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return '1;
            if (a == MIN && b == '1) return MIN;
            q = $signed(a) / $signed(b);
            return q;
         end
         3'd5: return (b == 0) ? '1 : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == MIN && b == '1) return 0;
            q = $signed(a) % $signed(b);
            return q;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_fast(input logic [2:0] o,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      return o[2] && (b == 0 || (!o[0] && a == MIN && b == '1));
   endfunction

   // model: 0 idle, 1 busy, 2 done
   int          ms [3] = '{0, 0, 0};
   int          done_at [3];
   logic [31:0] er [3];
   logic [4:0]  erd [3];
   bit          rflag [3] = '{0, 0, 0};
   logic [31:0] last [3];
   logic [4:0]  lrd [3];
   int          ncons [3] = '{0, 0, 0};

   always @(posedge clk) begin
      cyc++;
      for (int k = 0; k < 3; k++) begin
         if (!rst) begin
            ms[k] = 0;
            rflag[k] = 1;
         end else if (flush) begin
            ms[k] = 0;
         end else if (ms[k] == 0) begin
            if (prev_valid) begin
               er[k] = ref_op(op, op1, op2);
               erd[k] = rd;
               rflag[k] = 0;
               if (is_fast(op, op1, op2)) ms[k] = 2;
               else begin
                  ms[k] = 1;
                  done_at[k] = cyc + (32 >> k);
               end
            end
         end else if (ms[k] == 1) begin
            if (cyc == done_at[k]) ms[k] = 2;
         end else if (next_ready) begin
            ms[k] = 0;
            last[k] = res[k];
            lrd[k] = rdo[k];
            ncons[k]++;
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         chk("valid", k, 32'(vld[k]), 32'(ms[k] == 2 && rst));
         chk("ready", k, 32'(rdy[k]), 32'(ms[k] == 0 && rst));
         if (rst && ms[k] == 2) begin
            chk("result", k, res[k], er[k]);
            chk("rd", k, 32'(rdo[k]), 32'(erd[k]));
         end
         if (rflag[k]) begin
            chk("rst_result", k, res[k], 32'h0);
            chk("rst_rd", k, 32'(rdo[k]), 32'h0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (!(rdy[0] && rdy[1] && rdy[2]) && t < 200) begin
         tick();
         t++;
      end
      chk("idle_timeout", 0, 32'(t >= 200), 32'h0);
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r);
      op = o; op1 = a; op2 = b; rd = r;
      prev_valid = 1;
      tick();
      prev_valid = 0;
      op1 = $urandom; op2 = $urandom;
   endtask

   task automatic run_op(input string nm, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] exp);
      int n0 [3];
      int t;
      wait_idle();
      for (int k = 0; k < 3; k++) n0[k] = ncons[k];
      issue(o, a, b, r);
      t = 0;
      while (!(ncons[0] > n0[0] && ncons[1] > n0[1] && ncons[2] > n0[2])
             && t < 200) begin
         tick();
         t++;
      end
      chk({nm, "_timeout"}, 0, 32'(t >= 200), 32'h0);
      for (int k = 0; k < 3; k++) begin
         chk(nm, k, last[k], exp);
         chk({nm, "_rd"}, k, 32'(lrd[k]), 32'(r));
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 8)
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return MIN;
         3: return 32'($urandom % 16);
         4: return -32'($urandom % 16);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int nc [3];
      repeat (3) tick();
      rst = 1;
      tick();

      run_op("mul",    3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
      run_op("mulhu",  3'd3, '1, '1, 5'd6, 32'hFFFF_FFFE);
      run_op("mulh",   3'd1, '1, '1, 5'd7, 32'h0);
      run_op("mulhsu", 3'd2, '1, '1, 5'd8, 32'hFFFF_FFFF);
      run_op("div",    3'd4, -32'd7, 32'd2, 5'd9, 32'hFFFF_FFFD);
      run_op("rem",    3'd6, -32'd7, 32'd2, 5'd10, 32'hFFFF_FFFF);
      run_op("divu",   3'd5, 32'd7, 32'd2, 5'd11, 32'd3);
      run_op("remu",   3'd7, 32'd7, 32'd2, 5'd12, 32'd1);
      run_op("div0",   3'd4, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF);
      run_op("rem0",   3'd6, 32'd5, 32'd0, 5'd14, 32'd5);
      run_op("divovf", 3'd4, MIN, '1, 5'd15, MIN);
      run_op("removf", 3'd6, MIN, '1, 5'd16, 32'd0);

      // backpressure with a rejected accept attempt in the hold window
      wait_idle();
      next_ready = 0;
      issue(3'd5, 32'd100, 32'd7, 5'd20);
      repeat (40) tick();
      issue(3'd0, 32'd3, 32'd3, 5'd21);
      repeat (10) tick();
      next_ready = 1;
      tick();
      for (int k = 0; k < 3; k++) begin
         chk("bp_result", k, last[k], 32'd14);
         chk("bp_rd", k, 32'(lrd[k]), 32'd20);
      end

      // flush in the middle of BUSY
      wait_idle();
      for (int k = 0; k < 3; k++) nc[k] = ncons[k];
      issue(3'd0, 32'd1234, 32'd5678, 5'd3);
      repeat (4) tick();
      flush = 1;
      tick();
      flush = 0;
      for (int k = 0; k < 3; k++) chk("flush_ready", k, 32'(rdy[k]), 32'd1);
      repeat (40) tick();
      for (int k = 0; k < 3; k++)
         chk("flush_nocons", k, 32'(ncons[k] - nc[k]), 32'd0);
      run_op("after_flush", 3'd6, -32'd7, 32'd2, 5'd4, 32'hFFFF_FFFF);

      // reset in the middle of BUSY
      issue(3'd4, 32'd1000, 32'd3, 5'd9);
      repeat (5) tick();
      rst = 0;
      repeat (2) tick();
      for (int k = 0; k < 3; k++) begin
         chk("rst_valid", k, 32'(vld[k]), 32'd0);
         chk("rst_res", k, res[k], 32'd0);
      end
      rst = 1;
      tick();
      for (int k = 0; k < 3; k++) chk("rst_ready", k, 32'(rdy[k]), 32'd1);
      run_op("after_rst", 3'd0, 32'd6, 32'd7, 5'd1, 32'd42);

      // random traffic; the per-cycle compare does the checking
      for (int i = 0; i < 4000; i++) begin
         prev_valid = ($urandom % 3) == 0;
         op = 3'($urandom);
         op1 = pick();
         op2 = pick();
         rd = 5'($urandom);
         next_ready = ($urandom % 4) != 0;
         flush = ($urandom % 150) == 0;
         tick();
      end
      prev_valid = 0;
      flush = 0;
      next_ready = 1;
      repeat (50) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc %0d got timeout want finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule
